// File: rtl/riscv_lsu_pipe.sv
// RV32 load/store unit: one held bus request plus an in-order FIFO that tracks
// outstanding loads and turns returning read data into a registered writeback.
module riscv_lsu_pipe #(
    parameter int DEPTH       = 2,
    parameter int MEM_FUNCT_W = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   id_ex_rdy,
    output logic                   id_ex_ack,
    input  logic [MEM_FUNCT_W-1:0] id_ex_mem_funct,
    input  logic [31:0]            id_ex_op1,
    input  logic [31:0]            id_ex_op2,
    input  logic [31:0]            id_ex_mem_data,
    input  logic [4:0]             id_ex_wb_rsd,
    output logic                   data_bif_req,
    output logic                   data_bif_rnw,
    output logic [31:0]            data_bif_addr,
    output logic [3:0]             data_bif_wmask,
    output logic [31:0]            data_bif_wdata,
    input  logic                   data_bif_ack,
    input  logic                   data_bif_rvalid,
    input  logic [31:0]            data_bif_rdata,
    output logic                   wb_rf_write,
    output logic [4:0]             wb_rf_rsd,
    output logic [31:0]            wb_rf_data,
    output logic                   lsu_misaligned,
    output logic                   lsu_busy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [4:0] rsd;
        logic [4:0] ld;     // one-hot {LHU, LBU, LW, LH, LB}
        logic [1:0] off;
    } ld_entry_t;

    logic [31:0] ea;
    logic        f_lb, f_lh, f_lw, f_lbu, f_lhu, f_sb, f_sh, f_sw;
    logic        is_load, is_store, misaligned, issue;
    logic [3:0]  wmask_d;
    logic [31:0] wdata_d;

    logic             req_q, rnw_q, mis_q;
    logic [31:0]      addr_q, wdata_q;
    logic [3:0]       wmask_q;
    logic [4:0]       rsd_q, ld_q;
    logic [1:0]       off_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             wb_write_q;
    logic [4:0]       wb_rsd_q;
    logic [31:0]      wb_data_q;

    logic             held_load, slot_ok, push, pop;
    logic [CNT_W:0]   lif;
    ld_entry_t        fifo_mem [DEPTH];
    ld_entry_t        head, push_entry;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic [31:0]      ld_data;

    assign ea    = id_ex_op1 + id_ex_op2;
    assign f_lb  = id_ex_mem_funct[0];
    assign f_lh  = id_ex_mem_funct[1];
    assign f_lw  = id_ex_mem_funct[2];
    assign f_lbu = id_ex_mem_funct[3];
    assign f_lhu = id_ex_mem_funct[4];
    assign f_sb  = id_ex_mem_funct[5];
    assign f_sh  = id_ex_mem_funct[6];
    assign f_sw  = id_ex_mem_funct[7];

    assign is_load    = f_lb | f_lh | f_lw | f_lbu | f_lhu;
    assign is_store   = f_sb | f_sh | f_sw;
    assign misaligned = ((f_lh | f_lhu | f_sh) & ea[0]) |
                        ((f_lw | f_sw) & (ea[1:0] != 2'b00));

    // Byte-lane store steering; loads leave every lane at zero.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign wmask_d[gi] = f_sw |
                             (f_sh & (ea[1] == LANE[1])) |
                             (f_sb & (ea[1:0] == LANE));
        assign wdata_d[8*gi +: 8] = f_sw ? id_ex_mem_data[8*gi +: 8] :
                                    f_sh ? id_ex_mem_data[8*(gi%2) +: 8] :
                                    f_sb ? id_ex_mem_data[7:0] : 8'h00;
    end

    // A held load still owns a slot even when it is being acked, and a
    // same-cycle pop is deliberately not credited.
    assign held_load = req_q & rnw_q;
    assign lif       = {1'b0, count_q} + {{CNT_W{1'b0}}, held_load};
    assign slot_ok   = ~is_load | (lif < (CNT_W+1)'(DEPTH));
    assign id_ex_ack = id_ex_rdy & (~req_q | data_bif_ack) & slot_ok;
    assign issue     = id_ex_ack & (is_load | is_store) & ~misaligned;

    assign push = req_q & rnw_q & data_bif_ack;
    assign pop  = data_bif_rvalid & (count_q != '0);

    assign push_entry = '{rsd: rsd_q, ld: ld_q, off: off_q};
    assign head       = fifo_mem[rd_ptr_q];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        lane_b  = data_bif_rdata[{head.off, 3'b000} +: 8];
        lane_h  = head.off[1] ? data_bif_rdata[31:16] : data_bif_rdata[15:0];
        ld_data = data_bif_rdata;
        if (head.ld[0])      ld_data = {{24{lane_b[7]}}, lane_b};
        else if (head.ld[1]) ld_data = {{16{lane_h[15]}}, lane_h};
        else if (head.ld[3]) ld_data = {24'h0, lane_b};
        else if (head.ld[4]) ld_data = {16'h0, lane_h};
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_q      <= 1'b0;
            rnw_q      <= 1'b0;
            addr_q     <= '0;
            wmask_q    <= '0;
            wdata_q    <= '0;
            rsd_q      <= '0;
            ld_q       <= '0;
            off_q      <= '0;
            mis_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wb_write_q <= 1'b0;
            wb_rsd_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            if (issue) begin
                req_q   <= 1'b1;
                rnw_q   <= is_load;
                addr_q  <= {ea[31:2], 2'b00};
                wmask_q <= wmask_d;
                wdata_q <= wdata_d;
                rsd_q   <= id_ex_wb_rsd;
                ld_q    <= id_ex_mem_funct[4:0];
                off_q   <= ea[1:0];
            end else if (data_bif_ack) begin
                req_q <= 1'b0;
            end

            mis_q <= id_ex_ack & misaligned;

            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            // x0 loads retire silently; outputs keep the last real writeback.
            wb_write_q <= pop & (head.rsd != 5'd0);
            if (pop && head.rsd != 5'd0) begin
                wb_rsd_q  <= head.rsd;
                wb_data_q <= ld_data;
            end
        end
    end

    assign data_bif_req   = req_q;
    assign data_bif_rnw   = rnw_q;
    assign data_bif_addr  = addr_q;
    assign data_bif_wmask = wmask_q;
    assign data_bif_wdata = wdata_q;
    assign wb_rf_write    = wb_write_q;
    assign wb_rf_rsd      = wb_rsd_q;
    assign wb_rf_data     = wb_data_q;
    assign lsu_misaligned = mis_q;
    assign lsu_busy       = req_q | (count_q != '0);

endmodule
